// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: opcodes, FSM states, response record.
package mem_pkg;

  localparam logic [5:0] OP_LW = 6'b001101;
  localparam logic [5:0] OP_SW = 6'b001110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
  } resp_t;

endpackage

// File: rtl/mem_addr_gen.sv
// Effective word address (base + sign-extended offset, 32-bit wrap) and range check.
module mem_addr_gen #(
  parameter int unsigned SIZE          = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic [31:0]            base,
  input  logic [15:0]            offset,
  output logic [ADDRESS_WIDTH:0] addr,
  output logic                   in_range
);

  logic [31:0] eff;

  // A negative result wraps to a large unsigned value and fails the range test.
  always_comb begin
    eff      = base + {{16{offset[15]}}, offset};
    in_range = (eff < 32'(SIZE));
    addr     = eff[ADDRESS_WIDTH:0];
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one request at a time, single-cycle memory access, registered response.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned SIZE          = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [5:0]             req_opcode,
  input  logic [31:0]            req_base,
  input  logic [15:0]            req_offset,
  input  logic [31:0]            req_wdata,
  input  logic [4:0]             req_rd,
  output logic [5:0]             mem_opcode,
  output logic [ADDRESS_WIDTH:0] mem_addr,
  output logic [31:0]            mem_datain,
  input  logic [31:0]            mem_dataout,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic [4:0]             resp_rd,
  output logic                   resp_we,
  output logic                   resp_err
);

  state_t                 state;
  logic [5:0]             op_q;
  logic [31:0]            wdata_q;
  logic [4:0]             rd_q;
  logic [ADDRESS_WIDTH:0] addr_q;
  logic                   in_range_q;
  resp_t                  resp_q;

  logic [ADDRESS_WIDTH:0] gen_addr;
  logic                   gen_in_range;
  logic                   is_ld;
  logic                   is_st;

  mem_addr_gen #(
    .SIZE          (SIZE),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_addr_gen (
    .base     (req_base),
    .offset   (req_offset),
    .addr     (gen_addr),
    .in_range (gen_in_range)
  );

  assign is_ld = (op_q == OP_LW);
  assign is_st = (op_q == OP_SW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      addr_q     <= '0;
      in_range_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_opcode;
            wdata_q    <= req_wdata;
            rd_q       <= req_rd;
            addr_q     <= gen_addr;
            in_range_q <= gen_in_range;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          resp_q.data <= (is_ld && in_range_q) ? mem_dataout : '0;
          resp_q.rd   <= rd_q;
          resp_q.we   <= is_ld && in_range_q;
          resp_q.err  <= (is_ld || is_st) && !in_range_q;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Opcode is gated by rst so a reset landing in ACCESS can never commit a store.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_opcode = '0;
    mem_addr   = '0;
    mem_datain = '0;
    if (state == ACCESS) begin
      mem_addr   = addr_q;
      mem_datain = wdata_q;
      if (!rst && in_range_q && (is_ld || is_st)) mem_opcode = op_q;
    end
    resp_data = resp_valid ? resp_q.data : '0;
    resp_rd   = resp_valid ? resp_q.rd   : '0;
    resp_we   = resp_valid && resp_q.we;
    resp_err  = resp_valid && resp_q.err;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: attached 32-word memory plus an independent reference memory and response model.
module tb_mem_stage;

  localparam int unsigned SIZE = 32;
  localparam int unsigned AW   = 5;
  localparam logic [5:0] LW = 6'b001101;
  localparam logic [5:0] SW = 6'b001110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_base = '0;
  logic [15:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic [5:0]  mem_opcode;
  logic [AW:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_we;
  logic        resp_err;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem     [SIZE];
  logic [31:0] ref_mem [SIZE];

  always #5 clk = ~clk;

  mem_stage #(.SIZE(SIZE), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_we(resp_we), .resp_err(resp_err)
  );

  // Data memory: combinational read, write on OP_SW at the clock edge.
  assign mem_dataout = (mem_addr < 6'(SIZE)) ? mem[mem_addr[4:0]] : '0;
  always @(posedge clk)
    if (mem_opcode == SW && mem_addr < 6'(SIZE)) mem[mem_addr[4:0]] <= mem_datain;

  // Called at a negedge; returns at the negedge after the stage is back in IDLE.
  task automatic do_req(input logic [5:0] op, input logic [31:0] base, input logic [15:0] off,
                        input logic [31:0] wd, input logic [4:0] rd, input int hold, input bit keep_valid);
    longint      sum;
    logic [31:0] eff;
    bit          inr, ld, st, ewe, eerr;
    logic [5:0]  eop;
    logic [31:0] edata;
    int          diffs;
    sum   = (longint'(base) + longint'($signed(off))) % 64'sd4294967296;
    if (sum < 0) sum = sum + 64'sd4294967296;
    eff   = sum[31:0];
    inr   = (sum < longint'(SIZE));
    ld    = (op == LW);
    st    = (op == SW);
    eop   = ((ld || st) && inr) ? op : 6'd0;
    edata = (ld && inr) ? ref_mem[eff[4:0]] : 32'd0;
    ewe   = ld && inr;
    eerr  = (ld || st) && !inr;

    req_valid = 1'b1; req_opcode = op; req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
    checks++; if (req_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", req_ready); else passes++;
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL access_ready: got %b want 0", req_ready); else passes++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL access_resp_valid: got %b want 0", resp_valid); else passes++;
    checks++; if (mem_opcode !== eop) $display("FAIL access_opcode: got %h want %h", mem_opcode, eop); else passes++;
    if (eop != 6'd0) begin
      checks++; if (mem_addr !== eff[5:0]) $display("FAIL access_addr: got %0d want %0d", mem_addr, eff[5:0]); else passes++;
    end
    if (st && inr) begin
      checks++; if (mem_datain !== wd) $display("FAIL access_datain: got %h want %h", mem_datain, wd); else passes++;
      ref_mem[eff[4:0]] = wd;
    end
    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < int'(SIZE); i++) if (mem[i] !== ref_mem[i]) diffs++;
    checks++; if (diffs != 0) $display("FAIL mem_contents: got %0d differing words want 0", diffs); else passes++;
    for (int c = 0; c <= hold; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== edata || resp_rd !== rd || resp_we !== ewe || resp_err !== eerr)
        $display("FAIL resp[%0d]: got v=%b d=%h rd=%0d we=%b err=%b want v=1 d=%h rd=%0d we=%b err=%b",
                 c, resp_valid, resp_data, resp_rd, resp_we, resp_err, edata, rd, ewe, eerr);
      else passes++;
      checks++;
      if (req_ready !== 1'b0 || mem_opcode !== 6'd0 || mem_addr !== '0 || mem_datain !== '0)
        $display("FAIL resp_idle_mem[%0d]: got rdy=%b op=%h a=%0d d=%h want all 0", c, req_ready, mem_opcode, mem_addr, mem_datain);
      else passes++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL back_to_idle: got rdy=%b v=%b want rdy=1 v=0", req_ready, resp_valid);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== '0 || resp_rd !== '0 || resp_we !== 1'b0 ||
        resp_err !== 1'b0 || mem_opcode !== '0 || mem_addr !== '0 || mem_datain !== '0)
      $display("FAIL reset_state: got rdy=%b v=%b d=%h rd=%0d we=%b err=%b op=%h a=%0d di=%h want rdy=1 rest 0",
               req_ready, resp_valid, resp_data, resp_rd, resp_we, resp_err, mem_opcode, mem_addr, mem_datain);
    else passes++;
  endtask

  task automatic test_load();
    do_req(LW, 32'd1, 16'd2, 32'd0, 5'd7, 0, 1'b0);
  endtask

  task automatic test_store_load();
    do_req(SW, 32'd10, 16'd0, 32'h0000DEAD, 5'd3, 0, 1'b0);
    do_req(LW, 32'd10, 16'd0, 32'd0, 5'd9, 0, 1'b0);
  endtask

  task automatic test_out_of_range();
    do_req(LW, 32'd0, 16'hFFFF, 32'd0, 5'd2, 0, 1'b0);
    do_req(SW, 32'd31, 16'd1, 32'h12345678, 5'd4, 0, 1'b0);
    do_req(LW, 32'hFFFF_FFF0, 16'd20, 32'd0, 5'd5, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_req(LW, 32'd3, 16'd0, 32'd0, 5'd11, 5, 1'b1);
    do_req(LW, 32'd20, 16'hFFFB, 32'd0, 5'd12, 0, 1'b0);
  endtask

  task automatic test_reset_in_access();
    req_valid = 1'b1; req_opcode = SW; req_base = 32'd4; req_offset = 16'd0; req_wdata = 32'hBADC0DE; req_rd = 5'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_opcode !== 6'd0) $display("FAIL rst_access_opcode: got %h want 0", mem_opcode); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== '0 || resp_rd !== '0 || resp_we !== 1'b0 ||
        resp_err !== 1'b0 || mem_opcode !== '0 || mem_addr !== '0 || mem_datain !== '0)
      $display("FAIL rst_access_after: got rdy=%b v=%b op=%h a=%0d di=%h want rdy=1 rest 0",
               req_ready, resp_valid, mem_opcode, mem_addr, mem_datain);
    else passes++;
    checks++; if (mem[4] !== ref_mem[4]) $display("FAIL rst_access_cell4: got %h want %h", mem[4], ref_mem[4]); else passes++;
  endtask

  task automatic test_noop();
    do_req(6'b000000, 32'd5, 16'd0, 32'hFFFF_FFFF, 5'd6, 1, 1'b0);
    do_req(6'b111111, 32'd100, 16'd0, 32'd1, 5'd8, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] base;
    logic [15:0] off;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = LW;
        2:       op = SW;
        default: op = 6'($urandom);
      endcase
      if (n % 3 == 0) op = SW;
      base = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
      off  = 16'($signed($urandom_range(0, 16)) - 8);
      do_req(op, base, off, $urandom, 5'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(SIZE); i++) begin
      mem[i]     = 32'h1000 + 32'(i);
      ref_mem[i] = 32'h1000 + 32'(i);
    end
    mem[3]     = 32'd40;
    ref_mem[3] = 32'd40;
    test_reset();
    test_load();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_reset_in_access();
    test_noop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
